// File: rtl/biriscv_fetch_mq.sv
// Fetch stage with pipelined in-order I-cache requests and an instruction queue ahead of decode.
// Branches empty the queue and a drop counter discards responses still in flight.
module biriscv_fetch_mq #(
    parameter int unsigned FETCH_WIDTH     = 64,
    parameter int unsigned QUEUE_DEPTH     = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          fetch_accept_i,
    input  logic                          icache_accept_i,
    input  logic                          icache_valid_i,
    input  logic                          icache_error_i,
    input  logic                          icache_page_fault_i,
    input  logic [FETCH_WIDTH-1:0]        icache_inst_i,
    input  logic                          fetch_invalidate_i,
    input  logic                          branch_request_i,
    input  logic [31:0]                   branch_pc_i,
    input  logic [1:0]                    branch_priv_i,
    input  logic [31:0]                   next_pc_f_i,
    input  logic [FETCH_WIDTH/32-1:0]     next_taken_f_i,
    output logic                          fetch_valid_o,
    output logic [FETCH_WIDTH-1:0]        fetch_instr_o,
    output logic [31:0]                   fetch_pc_o,
    output logic [FETCH_WIDTH/32-1:0]     fetch_pred_branch_o,
    output logic                          fetch_fault_fetch_o,
    output logic                          fetch_fault_page_o,
    output logic                          icache_rd_o,
    output logic [31:0]                   icache_pc_o,
    output logic [1:0]                    icache_priv_o,
    output logic                          icache_flush_o,
    output logic [31:0]                   pc_f_o,
    output logic                          pc_accept_o,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_level_o
);

    localparam int unsigned FETCH_BYTES = FETCH_WIDTH / 8;
    localparam int unsigned OFF_W       = $clog2(FETCH_BYTES);
    localparam int unsigned SLOTS       = FETCH_WIDTH / 32;
    localparam int unsigned QP_W        = $clog2(QUEUE_DEPTH);
    localparam int unsigned LVL_W       = QP_W + 1;
    localparam int unsigned OUT_W       = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TP_W        = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W       = LVL_W + 1;

    typedef struct packed {
        logic [31:0]      pc;
        logic [SLOTS-1:0] pred;
    } tag_t;

    typedef struct packed {
        logic                   pf;
        logic                   err;
        logic [SLOTS-1:0]       pred;
        logic [31:0]            pc;
        logic [FETCH_WIDTH-1:0] inst;
    } entry_t;

    logic             r_active;
    logic [31:0]      r_pc_f;
    logic [1:0]       r_priv;
    logic             r_flush_pend;
    logic [OUT_W-1:0] r_outst;
    logic [OUT_W-1:0] r_drop;
    tag_t             r_tag [MAX_OUTSTANDING];
    logic [TP_W-1:0]  r_tag_wr;
    logic [TP_W-1:0]  r_tag_rd;
    entry_t           r_q [QUEUE_DEPTH];
    logic [QP_W-1:0]  r_q_wr;
    logic [QP_W-1:0]  r_q_rd;
    logic [LVL_W-1:0] r_level;

    logic        w_rd;
    logic        w_accept;
    logic        w_flush;
    logic        w_keep;
    logic        w_valid;
    logic        w_pop;
    logic [31:0] w_pc_al;
    tag_t        w_tag_head;
    entry_t      w_head;

    function automatic logic [TP_W-1:0] tp_inc(input logic [TP_W-1:0] p);
        return (p == TP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + TP_W'(1);
    endfunction

    // Credit check guarantees every in-flight response a queue slot.
    assign w_rd = r_active & ~branch_request_i & ~r_flush_pend & ~fetch_invalidate_i
                & (r_outst < OUT_W'(MAX_OUTSTANDING))
                & ((CNT_W'(r_outst) + CNT_W'(r_level)) < CNT_W'(QUEUE_DEPTH));
    assign w_accept   = w_rd & icache_accept_i;
    assign w_flush    = fetch_invalidate_i | r_flush_pend;
    assign w_pc_al    = {r_pc_f[31:OFF_W], OFF_W'(0)};
    assign w_tag_head = r_tag[r_tag_rd];
    assign w_keep     = icache_valid_i & (r_drop == '0) & ~branch_request_i;
    assign w_head     = r_q[r_q_rd];
    assign w_valid    = (r_level != '0) & ~branch_request_i;
    assign w_pop      = w_valid & fetch_accept_i;

    assign fetch_valid_o       = w_valid;
    assign fetch_instr_o       = w_head.inst;
    assign fetch_pc_o          = w_head.pc;
    assign fetch_pred_branch_o = w_head.pred;
    assign fetch_fault_fetch_o = w_head.err;
    assign fetch_fault_page_o  = w_head.pf;
    assign icache_rd_o         = w_rd;
    assign icache_pc_o         = w_pc_al;
    assign icache_priv_o       = r_priv;
    assign icache_flush_o      = w_flush;
    assign pc_f_o              = r_pc_f;
    assign pc_accept_o         = w_accept;
    assign queue_level_o       = r_level;

    // Fetch PC, privilege, activation and flush tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active     <= 1'b0;
            r_pc_f       <= '0;
            r_priv       <= 2'b11;
            r_flush_pend <= 1'b0;
        end else begin
            r_flush_pend <= w_flush & ~icache_accept_i;
            if (branch_request_i) begin
                r_active <= 1'b1;
                r_pc_f   <= branch_pc_i;
                r_priv   <= branch_priv_i;
            end else if (w_accept) begin
                r_pc_f <= next_pc_f_i;
            end
        end
    end

    // Outstanding and drop counters; on a branch everything still in flight is dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_outst <= '0;
            r_drop  <= '0;
        end else begin
            r_outst <= r_outst + OUT_W'(w_accept) - OUT_W'(icache_valid_i);
            if (branch_request_i)
                r_drop <= r_outst - OUT_W'(icache_valid_i);
            else if (icache_valid_i && r_drop != '0)
                r_drop <= r_drop - OUT_W'(1);
        end
    end

    // Tag FIFO pairs each response with the PC and prediction of its request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) r_tag[i] <= '0;
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_accept) begin
                r_tag[r_tag_wr] <= {w_pc_al, next_taken_f_i};
                r_tag_wr        <= tp_inc(r_tag_wr);
            end
            if (icache_valid_i)
                r_tag_rd <= tp_inc(r_tag_rd);
        end
    end

    // Instruction queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) r_q[i] <= '0;
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_level <= '0;
        end else if (branch_request_i) begin
            r_q_wr  <= '0;
            r_q_rd  <= '0;
            r_level <= '0;
        end else begin
            if (w_keep) begin
                r_q[r_q_wr] <= {icache_page_fault_i, icache_error_i, w_tag_head.pred,
                                w_tag_head.pc, icache_inst_i};
                r_q_wr      <= r_q_wr + QP_W'(1);
            end
            if (w_pop)
                r_q_rd <= r_q_rd + QP_W'(1);
            r_level <= r_level + LVL_W'(w_keep) - LVL_W'(w_pop);
        end
    end

endmodule
